// File: rtl/seq_pipe_accum_valrdy_pkg.sv
// Shared types and defaults for the valid/ready group accumulator.
package seq_pipe_accum_valrdy_pkg;

  // ACCUM collects samples; HOLD presents the finished group sum downstream.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Samples summed per output group unless overridden at instantiation.
  localparam int NSAMP_DEFAULT = 4;

endpackage

// File: rtl/seq_pipe_accum_ctrl.sv
// Control FSM: tracks ACCUM/HOLD, drives the handshake outputs and the
// datapath enables for the accumulator and sample counter.
module seq_pipe_accum_ctrl
  import seq_pipe_accum_valrdy_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in_val,
  input  logic out_rdy,
  input  logic last,      // counter is on the final sample of the group
  output logic in_rdy,
  output logic out_val,
  output logic acc_add,   // acc += in_data, cnt += 1
  output logic acc_load,  // acc  = in_data, cnt  = 1 (drain and refill)
  output logic acc_clr    // acc  = 0,       cnt  = 0 (drain only)
);

  state_t state_q, state_d;

  // State register; reset returns to ACCUM so out_val drops immediately.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs regardless of block order.
    if (reset) state_q <= ACCUM;
    else       state_q <= state_d;
  end

  // Next-state and handshake decode.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    in_rdy   = 1'b0;
    out_val  = 1'b0;
    acc_add  = 1'b0;
    acc_load = 1'b0;
    acc_clr  = 1'b0;
    unique case (state_q)
      ACCUM: begin
        in_rdy = !reset;
        if (in_val && !reset) begin
          acc_add = 1'b1;
          if (last) state_d = HOLD;
        end
      end
      HOLD: begin
        out_val = 1'b1;
        // Accept a new sample only in the cycle the held sum leaves, so the
        // group boundary costs no throughput.
        in_rdy  = out_rdy && !reset;
        if (out_rdy) begin
          state_d = ACCUM;
          if (in_val) acc_load = 1'b1;
          else        acc_clr  = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/seq_pipe_accum_valrdy.sv
// Sums groups of NSAMP unsigned 8-bit samples behind a valid/ready
// handshake and presents each group sum with a valid/ready handshake.
module seq_pipe_accum_valrdy
  import seq_pipe_accum_valrdy_pkg::*;
#(
  parameter int NSAMP = NSAMP_DEFAULT,
  localparam int CNT_W = $clog2(NSAMP),
  localparam int ACC_W = 8 + CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [7:0]       in_data,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [ACC_W-1:0] out_data
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSAMP - 1);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             acc_add, acc_load, acc_clr;

  seq_pipe_accum_ctrl u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .out_rdy  (out_rdy),
    .last     (cnt == CNT_LAST),
    .in_rdy   (in_rdy),
    .out_val  (out_val),
    .acc_add  (acc_add),
    .acc_load (acc_load),
    .acc_clr  (acc_clr)
  );

  // Accumulator and sample counter; the counter wraps to zero on the last
  // sample, which is harmless because HOLD always reloads or clears it.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the asynchronous reset clears only these two registers; there is
    // no memory here, so the whole datapath is in a known state after reset.
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (acc_load) begin
      acc <= ACC_W'(in_data);
      cnt <= CNT_W'(1);
    end else if (acc_clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (acc_add) begin
      acc <= acc + ACC_W'(in_data);
      cnt <= cnt + 1'b1;
    end
  end

  // The held sum is the accumulator itself; it cannot move while in HOLD.
  assign out_data = acc;

endmodule

// File: tb/tb_seq_pipe_accum_valrdy.sv
// Scoreboard bench for seq_pipe_accum_valrdy with NSAMP=4.
module tb_seq_pipe_accum_valrdy;

  localparam int ACC_W = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_val;
  logic             in_rdy;
  logic [7:0]       in_data;
  logic             out_val;
  logic             out_rdy;
  logic [ACC_W-1:0] out_data;

  int n_pass  = 0;
  int n_total = 0;
  int n_fire  = 0;
  logic [ACC_W-1:0] exp_q[$];

  seq_pipe_accum_valrdy #(.NSAMP(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Monitor: every output transfer pops the oldest expected sum.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && out_val && out_rdy) begin
        n_fire++;
        if (exp_q.size() == 0) begin
          check("unexpected_out_fire", {22'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          check("out_data", {22'd0, out_data}, {22'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Present one sample and hold it until it is accepted.
  task automatic send(input logic [7:0] d);
    int  n = 0;
    bit  done = 0;
    in_val  = 1'b1;
    in_data = d;
    while (!done) begin
      @(negedge clk);
      done = in_rdy;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 50) begin
        check("send_timeout", 32'(n), 32'd0);
        done = 1;
      end
    end
    in_val = 1'b0;
  endtask

  // Wait until the held sum has left.
  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (!out_val) break;
      n++;
      if (n > 20) begin
        check("drain_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    in_val = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset   = 1'b1;
    in_val  = 1'b0;
    in_data = 8'd0;
    out_rdy = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_rdy",   32'(in_rdy),   32'd0);
    check("rst_out_val",  32'(out_val),  32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_rdy", 32'(in_rdy), 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back group, latency 1, held one cycle
    exp_q.push_back(10'd100);
    send(8'd10); send(8'd20); send(8'd30); send(8'd40);
    check("t1_out_val",  32'(out_val),  32'd1);
    check("t1_out_data", 32'(out_data), 32'd100);
    @(posedge clk);
    #1;
    check("t1_out_val_drop", 32'(out_val), 32'd0);

    // Maximum sum needs the full 10 bits
    exp_q.push_back(10'd1020);
    repeat (4) send(8'd255);
    wait_idle();

    // Backpressure: held sum is stable and no input is taken
    out_rdy = 1'b0;
    exp_q.push_back(10'd100);
    send(8'd10); send(8'd20); send(8'd30); send(8'd40);
    in_val  = 1'b1;
    in_data = 8'd99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_val",  32'(out_val),  32'd1);
      check("bp_out_data", 32'(out_data), 32'd100);
      check("bp_in_rdy",   32'(in_rdy),   32'd0);
      @(posedge clk);
      #1;
    end
    in_val  = 1'b0;
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    check("bp_released", 32'(out_val), 32'd0);

    // Simultaneous out_fire and in_fire keeps the new sample
    exp_q.push_back(10'd100);
    exp_q.push_back(10'd20);
    send(8'd10); send(8'd20); send(8'd30); send(8'd40);
    send(8'd5); send(8'd5); send(8'd5); send(8'd5);
    wait_idle();

    // Reset mid-group discards the partial sum
    exp_q.push_back(10'd10);
    send(8'd7); send(8'd9);
    reset = 1'b1;
    #1;
    check("midrst_out_val", 32'(out_val), 32'd0);
    check("midrst_in_rdy",  32'(in_rdy),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("after_rst_out_val", 32'(out_val), 32'd0);
    check("after_rst_in_rdy",  32'(in_rdy),  32'd1);
    @(posedge clk);
    #1;
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    wait_idle();

    // Bubbles between samples do not end a group
    exp_q.push_back(10'd10);
    send(8'd1); idle(2);
    send(8'd2); idle(2);
    send(8'd3); idle(2);
    send(8'd4);
    wait_idle();
    idle(3);

    check("total_out_fires", 32'(n_fire),       32'd7);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
